// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/decode/execute sequencer for the arithmetic datapath
// Optional single-step PAUSE state and step port under INSTR_SEQUENCER_STEP_EN.
module instr_sequencer #(
  parameter int PC_W    = 8,
  parameter int MUL_CYC = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
`ifdef INSTR_SEQUENCER_STEP_EN
  input  logic            step,
`endif
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     ir,
  output logic            exec_en,
  output logic            busy,
  output logic            halted,
  output logic            illegal
);

  localparam int CNT_W = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(MUL_CYC - 1);
  localparam logic [4:0] OP_MUL  = 5'd4;
  localparam logic [4:0] OP_HALT = 5'b11111;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WAIT   = 3'd4,
    HALT   = 3'd5
`ifdef INSTR_SEQUENCER_STEP_EN
    ,PAUSE = 3'd6
`endif
  } state_t;

  // Where an instruction goes once it retires: single-step parks in PAUSE.
`ifdef INSTR_SEQUENCER_STEP_EN
  localparam state_t RETIRE_STATE = PAUSE;
`else
  localparam state_t RETIRE_STATE = FETCH;
`endif

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ill_q, ill_d;
  logic [4:0]        opcode;

  assign opcode = ir_q[31:27];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    ill_d   = ill_q;
    case (state_q)
      IDLE, HALT: begin
        if (start) begin
          pc_d    = '0;
          ill_d   = 1'b0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (opcode <= OP_MUL) begin
          state_d = EXEC;
        end else if (opcode == OP_HALT) begin
          state_d = HALT;
        end else begin
          ill_d   = 1'b1;
          state_d = HALT;
        end
      end
      EXEC: begin
        if ((MUL_CYC > 1) && (opcode == OP_MUL)) begin
          cnt_d   = WAIT_LOAD;
          state_d = WAIT;
        end else begin
          pc_d    = pc_q + 1'b1;
          state_d = RETIRE_STATE;
        end
      end
      WAIT: begin
        // Counter holds the WAIT cycles still to run, including this one.
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          pc_d    = pc_q + 1'b1;
          state_d = RETIRE_STATE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef INSTR_SEQUENCER_STEP_EN
      PAUSE: begin
        if (step) begin
          state_d = FETCH;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign imem_req  = (state_q == FETCH);
  assign imem_addr = pc_q;
  assign ir        = ir_q;
  assign exec_en   = (state_q == EXEC);
  assign busy      = (state_q != IDLE) && (state_q != HALT);
  assign halted    = (state_q == HALT);
  assign illegal   = ill_q;

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have parameter PC_W, default 8, program-counter and instruction-address width.
REQ-002 The block SHALL have parameter MUL_CYC, default 3, execute cycles for a mul instruction (minimum 1).
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port start  input  1  begin execution from address 0; sampled in IDLE and HALT only.
REQ-006 The block SHALL have port imem_req  output  1  instruction fetch request.
REQ-007 The block SHALL have port imem_addr  output  PC_W  fetch address, equal to pc.
REQ-008 The block SHALL have port imem_ack  input  1  fetch complete; imem_rdata valid in the same cycle.
REQ-009 The block SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-010 The block SHALL have port ir  output  32  instruction register driven to the arithmetic datapath.
REQ-011 The block SHALL have port exec_en  output  1  one-cycle datapath execute strobe.
REQ-012 The block SHALL have port busy  output  1  high in every state except IDLE and HALT.
REQ-013 The block SHALL have port halted  output  1  high in HALT.
REQ-014 The block SHALL have port illegal  output  1  sticky flag for an undefined opcode.

Function
REQ-015 The FSM SHALL have the states IDLE, FETCH, DECODE, EXEC, WAIT and HALT.
REQ-016 In IDLE or HALT, start=1 SHALL clear pc to 0 and illegal to 0, and move to FETCH on the next edge.
REQ-017 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc, both held stable until imem_ack.
REQ-018 On the edge where FETCH sees imem_ack=1, ir SHALL load imem_rdata and the FSM SHALL move to DECODE.
REQ-019 Fetch latency SHALL be unbounded, with no timeout.
REQ-020 The opcode SHALL be ir[31:27].
REQ-021 In DECODE, opcodes 0-4 (movsgpr, mov, add, sub, mul) SHALL go to EXEC.
REQ-022 In DECODE, opcode 5'b11111 SHALL go to HALT.
REQ-023 In DECODE, any other opcode SHALL set illegal and go to HALT.
REQ-024 exec_en SHALL be 1 for exactly the single EXEC cycle and 0 in every other state.
REQ-025 From EXEC, a non-mul opcode, or mul with MUL_CYC=1, SHALL increment pc and go to FETCH.
REQ-026 From EXEC, mul with MUL_CYC>1 SHALL go to WAIT.
REQ-027 WAIT SHALL last MUL_CYC-1 cycles, using a down-counter, then increment pc and go to FETCH.
REQ-028 pc increment SHALL wrap modulo 2^PC_W (all-ones to 0).
REQ-029 ir SHALL be held constant from DECODE through the end of EXEC/WAIT.
REQ-030 start asserted in FETCH, DECODE, EXEC or WAIT SHALL be ignored.
REQ-031 An imem_ack arriving outside FETCH SHALL be ignored.
REQ-032 Throughput for a non-mul instruction with zero-wait memory SHALL be one instruction per 3 cycles (FETCH, DECODE, EXEC).

Reset
REQ-033 rst_n=0 at a clock edge SHALL force IDLE, pc=0, ir=0, the wait counter to 0 and illegal=0.
REQ-034 During and after reset, all outputs SHALL read 0: imem_req, imem_addr, exec_en, busy and halted.
REQ-035 A reset applied mid-fetch SHALL drop imem_req in the cycle after the reset edge.
REQ-036 A reset applied mid-WAIT SHALL abandon the instruction without a pc increment.
REQ-037 rst_n SHALL have priority over start and imem_ack.

Configuration
REQ-038 Macro INSTR_SEQUENCER_STEP_EN SHALL, when defined, add input port step (1 bit) and state PAUSE.
REQ-039 With the macro defined, completion of EXEC/WAIT SHALL go to PAUSE after the pc increment instead of FETCH.
REQ-040 With the macro defined, PAUSE SHALL move to FETCH on step=1, and busy SHALL stay 1 in PAUSE.
REQ-041 With the macro undefined, there SHALL be no step port and no PAUSE state, and execution SHALL be continuous.

Verification
REQ-042 The bench SHALL cover: reset, then start; memory acks every fetch at once with add (0x1088_0001) then halt (0xF800_0000) -> imem_addr 0,1; exec_en one pulse 3 cycles after start; halted=1 after the 2nd fetch.
REQ-043 The bench SHALL cover: mul (opcode 00100) with MUL_CYC=3 -> exactly one exec_en pulse, next imem_req 3 cycles after exec_en, pc increments by 1.
REQ-044 The bench SHALL cover: ack delayed 5 cycles -> imem_req and imem_addr stable for all 5 cycles; ir unchanged until the ack edge.
REQ-045 The bench SHALL cover: opcode 01010 fetched -> illegal=1 and halted=1, no exec_en; then start -> illegal=0, pc=0.
REQ-046 The bench SHALL cover: PC_W=2 with four add instructions -> imem_addr sequence 0,1,2,3,0.
REQ-047 The bench SHALL cover: rst_n=0 while imem_req=1 and start=1 -> next cycle imem_req=0, busy=0, pc=0, stays IDLE.
